// File: rtl/gf2m_mult_pkg.sv
// Shared definitions for the digit-serial GF(2)[x] multiplier.
//   state_t    : controller states (IDLE, MUL, RED, DONE)
//   calc_k     : number of multiply cycles, ceil(m/d)
//   calc_r     : number of reduction cycles, ceil((m-1)/d)
//   clmul_md   : reference carryless product of an operand and a d-bit digit.
//                It works at a fixed maximum width, so callers slice off the
//                low m+d-1 bits they need.
package gf2m_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RED  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int CLMUL_MAX_W = 64;

    function automatic int calc_k(input int m, input int d);
        return (m + d - 1) / d;
    endfunction

    function automatic int calc_r(input int m, input int d);
        return (m + d - 2) / d;
    endfunction

    function automatic logic [2*CLMUL_MAX_W-2:0] clmul_md(
        input logic [CLMUL_MAX_W-1:0] a,
        input logic [CLMUL_MAX_W-1:0] digit,
        input int                     d
    );
        logic [2*CLMUL_MAX_W-2:0] p;
        p = '0;
        for (int j = 0; j < CLMUL_MAX_W; j++) begin
            if (j < d && digit[j]) begin
                p = p ^ ((2*CLMUL_MAX_W-1)'(a) << j);
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/gf2m_digit_serial_mult_clmul.sv
// Combinational M x D carryless multiplier.
//   a     : M-bit multiplicand
//   digit : D-bit slice of the multiplier
//   p     : M+D-1 bit carryless product
// One row of ANDed partial products per digit bit, each row shifted to its
// weight, then all rows XOR-folded together.
module gf_clmul_digit #(
    parameter int M = 8,
    parameter int D = 2
) (
    input  logic [M-1:0]   a,
    input  logic [D-1:0]   digit,
    output logic [M+D-2:0] p
);

    localparam int W = M + D - 1;

    logic [W-1:0] row [D];
    logic [W-1:0] p_acc;

    for (genvar gi = 0; gi < D; gi++) begin : g_row
        assign row[gi] = W'(a & {M{digit[gi]}}) << gi;
    end

    always_comb begin
        p_acc = '0;
        for (int j = 0; j < D; j++) begin
            p_acc = p_acc ^ row[j];
        end
    end

    assign p = p_acc;

endmodule

// File: rtl/gf2m_digit_serial_mult.sv
// Digit-serial GF(2)[x] multiplier with optional reduction modulo x^M + poly.
//   clk, rst_n          : clock and asynchronous active-low reset
//   in_valid/in_ready   : operand handshake (a, b, poly, red_en latched on accept)
//   out_valid/out_ready : result handshake; y held stable until taken
//   y                   : raw 2M-1 bit product, or zero-extended M-bit residue
// The multiplier b is consumed D bits per cycle, least significant digit first.
// Reduction folds D of the high degrees per cycle, top degree first.
module gf2m_digit_serial_mult
    import gf2m_mult_pkg::*;
#(
    parameter int M = 8,
    parameter int D = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [M-1:0]   a,
    input  logic [M-1:0]   b,
    input  logic [M-1:0]   poly,
    input  logic           red_en,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*M-2:0] y
);

    localparam int K  = calc_k(M, D);
    localparam int R  = calc_r(M, D);
    localparam int YW = 2 * M - 1;
    localparam int PW = M + D - 1;
    // Wide enough that shifting a digit product by any digit offset never
    // loses bits before truncation to the accumulator width.
    localparam int WW = PW + D * K;
    localparam int CW = $clog2(((K > R) ? K : R) + 1);

    state_t          state_q, state_d;
    logic [M-1:0]    a_q, a_d;
    logic [M-1:0]    b_q, b_d;
    logic [M-1:0]    poly_q, poly_d;
    logic            red_en_q, red_en_d;
    logic [YW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [PW-1:0]   clmul_p;
    logic [WW-1:0]   clmul_shifted;
    logic [YW-1:0]   mul_acc;
    logic [YW-1:0]   red_poly;
    logic [YW-1:0]   red_acc;

    // b_q is shifted right after every digit, so the current digit is always
    // its low D bits and digits past the top of b read as zero.
    gf_clmul_digit #(
        .M(M),
        .D(D)
    ) u_clmul (
        .a     (a_q),
        .digit (b_q[D-1:0]),
        .p     (clmul_p)
    );

    assign clmul_shifted = WW'(clmul_p) << (D * int'(cnt_q));
    assign mul_acc       = acc_q ^ YW'(clmul_shifted);
    assign red_poly      = YW'({1'b1, poly_q});

    // One reduction cycle: clear degrees 2M-2-D*cnt down to that minus D-1,
    // never below M. Bits are visited high-to-low so a fold that sets a lower
    // bit inside the same window is cleared in the same cycle.
    always_comb begin
        int deg;
        deg     = 0;
        red_acc = acc_q;
        for (int t = 0; t < D; t++) begin
            deg = (2 * M - 2) - D * int'(cnt_q) - t;
            if (deg >= M) begin
                if (red_acc[deg]) begin
                    red_acc = red_acc ^ (red_poly << (deg - M));
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        poly_d   = poly_q;
        red_en_d = red_en_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    poly_d   = poly;
                    red_en_d = red_en;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = MUL;
                end
            end
            MUL: begin
                acc_d = mul_acc;
                b_d   = b_q >> D;
                if (cnt_q == CW'(K - 1)) begin
                    cnt_d   = '0;
                    state_d = red_en_q ? RED : DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RED: begin
                acc_d = red_acc;
                if (cnt_q == CW'(R - 1)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            poly_q   <= '0;
            red_en_q <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            poly_q   <= poly_d;
            red_en_q <= red_en_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    // Partial accumulator contents are never exposed on y.
    assign y         = (state_q == DONE) ? acc_q : '0;

endmodule

// File: tb/tb_gf2m_digit_serial_mult.sv
module tb_gf2m_digit_serial_mult;

    localparam int NCFG = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;

    task automatic chk(input string nm, input int cfg, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cfg%0d: got 0x%0h expected 0x%0h (cycle %0d)", nm, cfg, act, exp, cyc);
        end
    endtask

    for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
        localparam int MM = (gi == 0) ? 8 : 5;
        localparam int DD = (gi == 2) ? 1 : (gi == 3) ? 3 : (gi == 4) ? 5 : 2;
        localparam int KK = (MM + DD - 1) / DD;
        localparam int RR = (MM - 1 + DD - 1) / DD;
        localparam int YW = 2 * MM - 1;

        logic          rst_n;
        logic          in_valid;
        logic          in_ready;
        logic [MM-1:0] a;
        logic [MM-1:0] b;
        logic [MM-1:0] poly;
        logic          red_en;
        logic          out_valid;
        logic          out_ready;
        logic [YW-1:0] y;

        gf2m_digit_serial_mult #(.M(MM), .D(DD)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .a         (a),
            .b         (b),
            .poly      (poly),
            .red_en    (red_en),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .y         (y)
        );

        // Polynomial product by schoolbook shift-and-add, then remainder by
        // long division with the monic modulus x^MM + mp.
        function automatic logic [YW-1:0] model(input logic [MM-1:0] ma, input logic [MM-1:0] mb,
                                                 input logic [MM-1:0] mp, input logic mr);
            logic [YW-1:0] p;
            logic [YW-1:0] m_poly;
            p      = '0;
            m_poly = YW'({1'b1, mp});
            for (int i = 0; i < MM; i++) begin
                if (mb[i]) p = p ^ (YW'(ma) << i);
            end
            if (mr) begin
                for (int k = YW - 1; k >= MM; k--) begin
                    if (p[k]) p = p ^ (m_poly << (k - MM));
                end
            end
            return p;
        endfunction

        logic [YW-1:0] exp_y_q [$];
        int            exp_lat_q [$];
        bit            busy    = 1'b0;
        bit            seen    = 1'b0;
        int            acc_cyc = 0;

        always @(negedge clk) begin
            if (rst_n !== 1'b1) begin
                chk("rst_in_ready", gi, 64'(in_ready), 64'd1);
                chk("rst_out_valid", gi, 64'(out_valid), 64'd0);
                chk("rst_y", gi, 64'(y), 64'd0);
                exp_y_q.delete();
                exp_lat_q.delete();
                busy = 1'b0;
                seen = 1'b0;
            end else if (busy) begin
                chk("busy_in_ready", gi, 64'(in_ready), 64'd0);
                if (out_valid === 1'b1) begin
                    if (!seen) begin
                        chk("latency", gi, 64'(cyc - acc_cyc), 64'(exp_lat_q[0]));
                        seen = 1'b1;
                    end
                    chk("y", gi, 64'(y), 64'(exp_y_q[0]));
                    if (out_ready === 1'b1) begin
                        $display("cfg%0d M=%0d D=%0d result y=0x%0h expected=0x%0h cycle %0d",
                                 gi, MM, DD, y, exp_y_q[0], cyc);
                        void'(exp_y_q.pop_front());
                        void'(exp_lat_q.pop_front());
                        busy = 1'b0;
                        seen = 1'b0;
                    end
                end else if (seen) begin
                    chk("valid_held", gi, 64'(out_valid), 64'd1);
                end
            end else begin
                chk("idle_in_ready", gi, 64'(in_ready), 64'd1);
                chk("idle_out_valid", gi, 64'(out_valid), 64'd0);
                if (in_valid === 1'b1 && in_ready === 1'b1) begin
                    exp_y_q.push_back(model(a, b, poly, red_en));
                    exp_lat_q.push_back(red_en ? (KK + RR + 1) : (KK + 1));
                    acc_cyc = cyc;
                    busy    = 1'b1;
                    seen    = 1'b0;
                end
            end
        end

        task automatic junk(input bit allow_valid);
            in_valid = allow_valid ? 1'($urandom_range(0, 1)) : 1'b0;
            a        = MM'($urandom);
            b        = MM'($urandom);
            poly     = MM'($urandom);
            red_en   = 1'($urandom_range(0, 1));
        endtask

        task automatic present_op(input logic [63:0] ta, input logic [63:0] tb_v,
                                  input logic [63:0] tp, input logic tr);
            int n;
            n = 0;
            @(posedge clk);
            #1;
            a        = ta[MM-1:0];
            b        = tb_v[MM-1:0];
            poly     = tp[MM-1:0];
            red_en   = tr;
            in_valid = 1'b1;
            @(negedge clk);
            while (in_ready !== 1'b1 && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (in_ready !== 1'b1) chk("in_ready_timeout", gi, 64'(in_ready), 64'd1);
            @(posedge clk);
            #1;
            junk(1'b0);
        endtask

        task automatic finish_op(input int hold);
            int n;
            bit got;
            n   = 0;
            got = 1'b0;
            while (!got && n < 200) begin
                @(negedge clk);
                if (out_valid === 1'b1) begin
                    got = 1'b1;
                end else begin
                    @(posedge clk);
                    #1;
                    junk(1'b1);
                    n++;
                end
            end
            if (!got) begin
                chk("out_valid_timeout", gi, 64'(out_valid), 64'd1);
            end else begin
                for (int h = 0; h < hold; h++) begin
                    @(posedge clk);
                    #1;
                    junk(1'b1);
                end
                @(posedge clk);
                #1;
                in_valid  = 1'b0;
                out_ready = 1'b1;
                @(posedge clk);
                #1;
                out_ready = 1'b0;
            end
        endtask

        task automatic do_op(input logic [63:0] ta, input logic [63:0] tb_v, input logic [63:0] tp,
                             input logic tr, input int hold, input bit use_pin, input logic [63:0] pin);
            if (use_pin) chk("model_pin", gi, 64'(model(ta[MM-1:0], tb_v[MM-1:0], tp[MM-1:0], tr)), pin);
            present_op(ta, tb_v, tp, tr);
            finish_op(hold);
        endtask

        initial begin
            rst_n     = 1'b0;
            in_valid  = 1'b0;
            out_ready = 1'b0;
            a         = '0;
            b         = '0;
            poly      = '0;
            red_en    = 1'b0;
            repeat (3) @(posedge clk);
            #2 rst_n = 1'b1;

            case (gi)
                0: begin
                    do_op(64'h57, 64'h83, 64'h1B, 1'b1, 0, 1'b1, 64'h00C1);
                    do_op(64'h57, 64'h83, 64'h1B, 1'b0, 0, 1'b1, 64'h2B79);
                    do_op(64'h00, 64'hFF, 64'h1B, 1'b1, 0, 1'b1, 64'h0000);
                    do_op(64'h01, 64'hA5, 64'h1B, 1'b1, 0, 1'b1, 64'h00A5);
                    // consumer stalls for 10 cycles while junk requests arrive
                    do_op(64'h57, 64'h83, 64'h1B, 1'b1, 10, 1'b1, 64'h00C1);
                    // reset in the middle of the reduction phase
                    present_op(64'h57, 64'h83, 64'h1B, 1'b1);
                    repeat (KK + 1) @(posedge clk);
                    #3 rst_n = 1'b0;
                    #1;
                    chk("midop_rst_out_valid", gi, 64'(out_valid), 64'd0);
                    chk("midop_rst_in_ready", gi, 64'(in_ready), 64'd1);
                    chk("midop_rst_y", gi, 64'(y), 64'd0);
                    repeat (2) @(posedge clk);
                    #2 rst_n = 1'b1;
                    do_op(64'h02, 64'h80, 64'h1B, 1'b1, 0, 1'b1, 64'h001B);
                end
                1: begin
                    // (x^4+x^3+x^2+x+1)^2 = x^8+x^6+x^4+x^2+1 == x^4+x mod x^5+x^2+1
                    do_op(64'h1F, 64'h1F, 64'h05, 1'b1, 0, 1'b1, 64'h12);
                    do_op(64'h1F, 64'h1F, 64'h05, 1'b0, 0, 1'b1, 64'h155);
                end
                default: ;
            endcase

            for (int i = 0; i < 30; i++) begin
                do_op(64'($urandom), 64'($urandom), 64'($urandom), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 3)), 1'b0, 64'd0);
            end
            repeat (2) @(posedge clk);
            done_cnt++;
        end
    end

    initial begin
        int n;
        n = 0;
        while (done_cnt < NCFG && n < 60000) begin
            @(posedge clk);
            n++;
        end
        if (done_cnt < NCFG) chk("global_timeout", -1, 64'(done_cnt), 64'(NCFG));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
